// File: rtl/drac_pkg.sv
// Shared types and constants for the execute-stage branch resolution unit.
//   instr_type_t      : control-transfer kinds; any unlisted encoding is a non-branch
//   branch_decision_t : resolved direction
//   LINK_REG_X1/X5    : registers treated as return-address links for RAS hints
package drac_pkg;

    typedef enum logic [3:0] {
        BEQ  = 4'd0,
        BNE  = 4'd1,
        BLT  = 4'd2,
        BGE  = 4'd3,
        BLTU = 4'd4,
        BGEU = 4'd5,
        JAL  = 4'd6,
        JALR = 4'd7
    } instr_type_t;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } branch_decision_t;

    localparam logic [4:0] LINK_REG_X1 = 5'd1;
    localparam logic [4:0] LINK_REG_X5 = 5'd5;

    // True when the register index is one of the return-address link registers.
    function automatic logic is_link_reg(input logic [4:0] idx);
        return (idx == LINK_REG_X1) || (idx == LINK_REG_X5);
    endfunction

endpackage

// File: rtl/branch_resolve_unit_ras_stack.sv
// Return-address stack: circular buffer with a top pointer and a saturating
// occupancy count. A push on a full stack overwrites the oldest entry.
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   push, pop     : update strobes (already qualified by the caller)
//   push_data     : return address to push
//   top           : current top entry, 0 when empty
//   empty         : no valid entries
module ras_stack
    import drac_pkg::*;
#(
    parameter int RAS_DEPTH = 8,
    parameter int PC_W      = 40
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            empty
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]  entries_r [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] ptr_inc_s;
    logic [PTR_W-1:0] ptr_dec_s;

    // Depth is a power of two, so pointer arithmetic wraps naturally.
    assign ptr_inc_s = ptr_r + PTR_W'(1'b1);
    assign ptr_dec_s = ptr_r - PTR_W'(1'b1);
    assign empty     = (count_r == {CNT_W{1'b0}});

    // Top-of-stack read, forced to zero when nothing is held.
    always_comb begin
        top = {PC_W{1'b0}};
        if (empty) begin
            top = {PC_W{1'b0}};
        end else begin
            top = entries_r[ptr_r];
        end
    end

    // Pointer, count and entry storage update.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr_r   <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            for (int i = 0; i < RAS_DEPTH; i++) begin
                entries_r[i] <= {PC_W{1'b0}};
            end
        end else if (push && pop && !empty) begin
            // Call-through-return: swap the top entry in place.
            entries_r[ptr_r] <= push_data;
        end else if (push) begin
            ptr_r              <= ptr_inc_s;
            entries_r[ptr_inc_s] <= push_data;
            if (count_r != FULL_CNT) begin
                count_r <= count_r + CNT_W'(1'b1);
            end
        end else if (pop && !empty) begin
            ptr_r   <= ptr_dec_s;
            count_r <= count_r - CNT_W'(1'b1);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: evaluates conditional branches, JAL and
// JALR, checks the front-end prediction and registers the redirect result
// into a single valid/ready output slot. Also drives the RAS and two
// saturating performance counters.
//   clk_i, rstn_i        : clock, asynchronous active-low reset
//   valid_i / ready_o    : request handshake
//   instr_type_i, pc_i, data_rs1_i, data_rs2_i, imm_i, rs1_i, rd_i : request
//   pred_taken_i, pred_target_i : front-end prediction
//   flush_i              : kill output slot, drop same-cycle request
//   valid_o / ready_i    : result handshake
//   taken_o, mispredict_o, result_o, link_pc_o : registered result
//   ras_top_o, ras_empty_o                     : RAS state
//   branch_cnt_o, mispred_cnt_o                : performance counters
module branch_resolve_unit
    import drac_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int PC_W      = 40,
    parameter int RAS_DEPTH = 8,
    parameter int CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  instr_type_t      instr_type_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic [XLEN-1:0]  data_rs1_i,
    input  logic [XLEN-1:0]  data_rs2_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rd_i,
    input  logic             pred_taken_i,
    input  logic [PC_W-1:0]  pred_target_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output branch_decision_t taken_o,
    output logic             mispredict_o,
    output logic [PC_W-1:0]  result_o,
    output logic [PC_W-1:0]  link_pc_o,
    output logic [PC_W-1:0]  ras_top_o,
    output logic             ras_empty_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    logic             equal_s, less_s, less_u_s;
    logic             is_ctrl_s;
    branch_decision_t taken_s;
    logic [XLEN-1:0]  br_sum_s, jalr_sum_s;
    logic [PC_W-1:0]  target_s, link_s, result_s;
    logic             mispredict_s, accept_s, ras_push_s, ras_pop_s;
    logic             unused_sum_bits_s;

    logic             valid_r, mispredict_r;
    branch_decision_t taken_r;
    logic [PC_W-1:0]  result_r, link_r;
    logic [CNT_W-1:0] branch_cnt_r, mispred_cnt_r;

    assign equal_s  = (data_rs1_i == data_rs2_i);
    assign less_s   = ($signed(data_rs1_i) < $signed(data_rs2_i));
    assign less_u_s = (data_rs1_i < data_rs2_i);

    // Targets are formed at XLEN and truncated; upper sum bits are discarded.
    assign br_sum_s          = XLEN'(pc_i) + imm_i;
    assign jalr_sum_s        = data_rs1_i + imm_i;
    assign unused_sum_bits_s = ^{br_sum_s, jalr_sum_s};
    assign link_s            = pc_i + PC_W'(3'd4);

    // Direction decode; unknown encodings are treated as non-branches.
    always_comb begin
        taken_s   = NOT_TAKEN;
        is_ctrl_s = 1'b1;
        case (instr_type_i)
            BEQ:       taken_s = equal_s  ? TAKEN : NOT_TAKEN;
            BNE:       taken_s = equal_s  ? NOT_TAKEN : TAKEN;
            BLT:       taken_s = less_s   ? TAKEN : NOT_TAKEN;
            BGE:       taken_s = less_s   ? NOT_TAKEN : TAKEN;
            BLTU:      taken_s = less_u_s ? TAKEN : NOT_TAKEN;
            BGEU:      taken_s = less_u_s ? NOT_TAKEN : TAKEN;
            JAL, JALR: taken_s = TAKEN;
            default: begin
                taken_s   = NOT_TAKEN;
                is_ctrl_s = 1'b0;
            end
        endcase
    end

    // Target, next-PC and misprediction evaluation.
    always_comb begin
        target_s = br_sum_s[PC_W-1:0];
        if (instr_type_i == JALR) begin
            target_s = {jalr_sum_s[PC_W-1:1], 1'b0};
        end else begin
            target_s = br_sum_s[PC_W-1:0];
        end
        result_s     = (taken_s == TAKEN) ? target_s : link_s;
        mispredict_s = is_ctrl_s &
                       (((taken_s == TAKEN) != pred_taken_i) |
                        ((taken_s == TAKEN) & (target_s != pred_target_i)));
    end

    assign ready_o    = ~valid_r | ready_i;
    assign accept_s   = valid_i & ready_o & ~flush_i;
    assign ras_push_s = accept_s & ((instr_type_i == JAL) | (instr_type_i == JALR)) &
                        is_link_reg(rd_i);
    assign ras_pop_s  = accept_s & (instr_type_i == JALR) & is_link_reg(rs1_i) &
                        (rs1_i != rd_i);

    // Output slot: flush kills it, acceptance refills it, a drain empties it.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_r      <= 1'b0;
            taken_r      <= NOT_TAKEN;
            mispredict_r <= 1'b0;
            result_r     <= {PC_W{1'b0}};
            link_r       <= {PC_W{1'b0}};
        end else if (flush_i) begin
            valid_r <= 1'b0;
        end else if (accept_s) begin
            valid_r      <= 1'b1;
            taken_r      <= taken_s;
            mispredict_r <= mispredict_s;
            result_r     <= result_s;
            link_r       <= link_s;
        end else if (ready_i) begin
            valid_r <= 1'b0;
        end
    end

    // Saturating performance counters; flush does not clear them.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            branch_cnt_r  <= {CNT_W{1'b0}};
            mispred_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (accept_s && is_ctrl_s && (branch_cnt_r != {CNT_W{1'b1}})) begin
                branch_cnt_r <= branch_cnt_r + CNT_W'(1'b1);
            end
            if (accept_s && mispredict_s && (mispred_cnt_r != {CNT_W{1'b1}})) begin
                mispred_cnt_r <= mispred_cnt_r + CNT_W'(1'b1);
            end
        end
    end

    ras_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .PC_W      (PC_W)
    ) u_ras (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .push      (ras_push_s),
        .pop       (ras_pop_s),
        .push_data (link_s),
        .top       (ras_top_o),
        .empty     (ras_empty_o)
    );

    assign valid_o       = valid_r;
    assign taken_o       = taken_r;
    assign mispredict_o  = mispredict_r;
    assign result_o      = result_r;
    assign link_pc_o     = link_r;
    assign branch_cnt_o  = branch_cnt_r;
    assign mispred_cnt_o = mispred_cnt_r;

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised execute-stage branch resolution unit. It resolves conditional branches, JAL and JALR and compares each outcome against the front-end prediction. It delivers a registered redirect/link result through a valid/ready output stage. It also maintains a return-address stack (RAS) and two saturating performance counters. It replaces the combinational branch unit in the integer execute pipe.

## Interface
Parameters:
- XLEN, 64, operand width of rs1/rs2/imm.
- PC_W, 40, PC width; PC_W ≤ XLEN; targets are truncated to PC_W.
- RAS_DEPTH, 8, RAS entries; power of two, ≥ 2.
- CNT_W, 32, performance counter width.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- valid_i  in  1  request valid.
- ready_o  out  1  request accepted when valid_i & ready_o.
- instr_type_i  in  instr_type_t  one of BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR; any other value is a non-branch.
- pc_i  in  PC_W  instruction PC.
- data_rs1_i, data_rs2_i  in  XLEN  operands.
- imm_i  in  XLEN  sign-extended immediate.
- rs1_i, rd_i  in  5  register indices, used for RAS hints.
- pred_taken_i  in  1  front-end predicted direction.
- pred_target_i  in  PC_W  front-end predicted target.
- flush_i  in  1  kill the in-flight output and drop any same-cycle request.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- taken_o  out  branch_decision_t  resolved direction.
- mispredict_o  out  1  redirect required.
- result_o  out  PC_W  correct next PC.
- link_pc_o  out  PC_W  pc + 4, written to rd.
- ras_top_o  out  PC_W  current RAS top, 0 when empty.
- ras_empty_o  out  1  RAS holds no entries.
- branch_cnt_o, mispred_cnt_o  out  CNT_W  performance counters.

## Operation
- Conditions:
  - equal: rs1 == rs2.
  - less: signed rs1 < rs2.
  - less_u: unsigned rs1 < rs2.
  - Full XLEN compare.
- Direction:
  - BEQ takes on equal; BNE on !equal.
  - BLT on less; BGE on !less.
  - BLTU on less_u; BGEU on !less_u.
  - JAL and JALR are always TAKEN.
  - Non-branch types resolve NOT_TAKEN and never mispredict.
- Target:
  - Branches and JAL: (pc + imm) mod 2^PC_W.
  - JALR: ((rs1 + imm) & ~1) truncated to PC_W.
- result_o = taken ? target : pc + 4. link_pc_o = pc + 4, with PC_W wrap-around.
- Misprediction: mispredict = taken != pred_taken, or (taken & target != pred_target).
- RAS link registers are x1 and x5.
  - push: JAL or JALR with rd a link register.
  - pop: JALR with rs1 a link register and rs1 != rd.
  - push value: pc + 4.
- RAS updates occur only on an accepted request when flush_i is low.
  - Pop and push in the same request: replace the top entry; count unchanged.
  - Push when full: circular overwrite of the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty: no-op; count stays 0.
- Counters:
  - branch_cnt increments on every accepted branch/jump.
  - mispred_cnt increments on every accepted mispredicting request.
  - Both saturate at all-ones and are not cleared by flush_i.

## Timing
- Latency is 1 cycle. The result is registered into a single output slot on acceptance.
- ready_o = !valid_o | ready_i. The slot refills in the same cycle it drains, giving full throughput.
- valid_o holds, and all outputs stay stable, while ready_i is low.
- flush_i clears valid_o next cycle. A request presented in the same cycle as flush_i is dropped and causes no RAS or counter update.
- RAS and counter updates are visible one cycle after acceptance.
- Reset values:
  - valid_o = 0, taken_o = NOT_TAKEN, mispredict_o = 0.
  - result_o = 0, link_pc_o = 0, ras_top_o = 0, ras_empty_o = 1.
  - Both counters = 0; RAS pointer and count = 0.
- Reset mid-operation discards the output slot and empties the RAS immediately (asynchronous).

## Structure
- drac_pkg holds instr_type_t, branch_decision_t (TAKEN/NOT_TAKEN) and the link-register constants.
- Sub-module ras_stack holds the circular buffer, pointer and count. Its interface is push, pop, push_data, top, empty, and its parameters are RAS_DEPTH and PC_W.
- Resolution logic is combinational in the top module, feeding the output register.

## Test plan
- BLT with rs1 = -1, rs2 = 1, pc = 0x1000, imm = 0x20, pred_taken = 0 → next cycle: taken, result 0x1020, mispredict = 1, mispred_cnt = 1.
- BLTU with the same operands, pred_taken = 0 → NOT_TAKEN, result 0x1004, mispredict = 0.
- JALR with rs1 = 0x2003, imm = 0, pred_target = 0x2002, rd = x0, rs1 = x1 after a JAL rd = x1 at pc 0x3000 → result 0x2002, mispredict = 0, RAS pops 0x3004, ras_empty = 1.
- 9 pushes at RAS_DEPTH = 8 from pc 0x0, 0x10, … → top = 0x84; 8 pops then empty; a 9th pop stays empty with top = 0.
- ready_i low for 3 cycles with valid_i high → outputs stable and no second acceptance. Then flush_i → valid_o = 0 and counters unchanged by the dropped request.
- Async reset asserted mid-stream → all outputs reach reset values without a clock edge.
